// File: rtl/program_loader_pkg.sv
// rtl/program_loader_pkg.sv - shared constants and state encodings for the program loader
// Contents: frame marker, store depth, loader FSM and UART receiver state encodings.
package program_loader_pkg;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam int         MAX_ENTRIES   = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_COUNT  = 3'd1,
        ST_DATA   = 3'd2,
        ST_CHECK  = 3'd3,
        ST_COMMIT = 3'd4
    } loader_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/program_loader_uart_rx_byte.sv
// rtl/program_loader_uart_rx_byte.sv - 8N1 UART byte receiver with input synchronizer
// Ports: clk, reset_n (async, active-low), i_rx (async serial line, idle high),
//        o_byte_tdata (received byte), o_byte_valid (1-cycle, good stop bit),
//        o_frame_err (1-cycle, stop bit sampled low).
module uart_rx_byte
    import program_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_rx,
    output logic [7:0] o_byte_tdata,
    output logic       o_byte_valid,
    output logic       o_frame_err
);

    localparam int              CW   = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0]   HALF = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0]   FULL = CW'(CLKS_PER_BIT - 1);

    rx_state_t       r_state;
    rx_state_t       w_next;
    logic            r_rx_meta;
    logic            r_rx_sync;
    logic            r_rx_prev;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_bit;
    logic [7:0]      r_shift;
    logic            r_valid;
    logic            r_ferr;

    logic w_fall;
    logic w_cnt_half;
    logic w_cnt_full;

    assign w_fall     = r_rx_prev & ~r_rx_sync;
    assign w_cnt_half = (r_cnt == HALF);
    assign w_cnt_full = (r_cnt == FULL);

    always_comb begin
        w_next = r_state;
        case (r_state)
            RX_IDLE:  if (w_fall) w_next = RX_START;
            // Start bit must still be low at mid-bit, otherwise it was a glitch.
            RX_START: if (w_cnt_half) w_next = r_rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA:  if (w_cnt_full && (r_bit == 3'd7)) w_next = RX_STOP;
            RX_STOP:  if (w_cnt_full) w_next = RX_IDLE;
            default:  w_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // Synchronizer resets to line-idle so reset release never looks like a start bit.
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
            r_state   <= RX_IDLE;
            r_cnt     <= '0;
            r_bit     <= '0;
            r_shift   <= '0;
            r_valid   <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            r_rx_meta <= i_rx;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
            r_state   <= w_next;
            r_valid   <= 1'b0;
            r_ferr    <= 1'b0;

            // Counter restarts on entry to each state and after every mid-bit sample.
            if ((r_state == RX_IDLE) || (w_next != r_state) || w_cnt_full)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + 1'b1;

            if (r_state == RX_START)
                r_bit <= '0;

            if ((r_state == RX_DATA) && w_cnt_full) begin
                r_shift <= {r_rx_sync, r_shift[7:1]};
                r_bit   <= r_bit + 1'b1;
            end

            if ((r_state == RX_STOP) && w_cnt_full) begin
                if (r_rx_sync) r_valid <= 1'b1;
                else           r_ferr  <= 1'b1;
            end
        end
    end

    assign o_byte_tdata = r_shift;
    assign o_byte_valid = r_valid;
    assign o_frame_err  = r_ferr;

endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - UART program loader with shadow buffer and atomic commit
// Ports: clk, reset_n (async, active-low), rx (UART in), rd_addr (CPU PC),
//        rd_opcode/rd_arg (combinational store read), cpu_hold (frame in flight),
//        load_done (1-cycle after commit), load_error (sticky until next SYNC).
module program_loader
    import program_loader_pkg::*;
#(
    parameter int         CLK_HZ       = 1000000,
    parameter int         BAUD         = 9600,
    parameter int         TIMEOUT_CLKS = 20 * (CLK_HZ / BAUD),
    parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx,
    input  logic [2:0] rd_addr,
    output logic [3:0] rd_opcode,
    output logic [3:0] rd_arg,
    output logic       cpu_hold,
    output logic       load_done,
    output logic       load_error
);

    localparam int            CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int            TW           = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TW-1:0] TMO_LIMIT    = TW'(TIMEOUT_CLKS);
    localparam logic [7:0]    MAX_N        = 8'(MAX_ENTRIES);

    logic [7:0]    w_byte;
    logic          w_byte_valid;
    logic          w_frame_err;

    loader_state_t r_state;
    loader_state_t w_next;
    logic          w_abort;
    logic          w_tmo_hit;
    logic          w_in_frame;

    logic [7:0]    r_active [MAX_ENTRIES];
    logic [7:0]    r_shadow [MAX_ENTRIES];
    logic [3:0]    r_n;
    logic [3:0]    r_idx;
    logic [7:0]    r_chk;
    logic [TW-1:0] r_tmo;
    logic          r_done;
    logic          r_err;

    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_rx         (rx),
        .o_byte_tdata (w_byte),
        .o_byte_valid (w_byte_valid),
        .o_frame_err  (w_frame_err)
    );

    assign w_in_frame = (r_state == ST_COUNT) || (r_state == ST_DATA) || (r_state == ST_CHECK);
    assign w_tmo_hit  = (r_tmo == TMO_LIMIT);

    always_comb begin
        w_next  = r_state;
        w_abort = 1'b0;
        case (r_state)
            ST_IDLE:   if (w_byte_valid && (w_byte == SYNC_BYTE)) w_next = ST_COUNT;
            ST_COUNT:  if (w_byte_valid) begin
                           if ((w_byte == 8'h00) || (w_byte > MAX_N)) w_abort = 1'b1;
                           else                                      w_next  = ST_DATA;
                       end
            ST_DATA:   if (w_byte_valid && (r_idx == (r_n - 4'd1))) w_next = ST_CHECK;
            ST_CHECK:  if (w_byte_valid) begin
                           if (w_byte == r_chk) w_next  = ST_COMMIT;
                           else                 w_abort = 1'b1;
                       end
            ST_COMMIT: w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
        // A byte arriving on the expiry cycle takes priority over the timeout.
        if (w_in_frame && !w_byte_valid && (w_frame_err || w_tmo_hit))
            w_abort = 1'b1;
        if (w_abort)
            w_next = ST_IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_n     <= '0;
            r_idx   <= '0;
            r_chk   <= '0;
            r_tmo   <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            for (int i = 0; i < MAX_ENTRIES; i++) begin
                r_active[i] <= 8'h00;
                r_shadow[i] <= 8'h00;
            end
        end else begin
            r_state <= w_next;
            r_done  <= (r_state == ST_COMMIT);

            if (w_in_frame && !w_byte_valid && !w_tmo_hit)
                r_tmo <= r_tmo + 1'b1;
            else if (!w_in_frame || w_byte_valid)
                r_tmo <= '0;

            if (w_abort)
                r_err <= 1'b1;
            else if ((r_state == ST_IDLE) && (w_next == ST_COUNT))
                r_err <= 1'b0;

            if ((r_state == ST_COUNT) && (w_next == ST_DATA)) begin
                r_n   <= w_byte[3:0];
                r_chk <= w_byte;
                r_idx <= '0;
            end

            if ((r_state == ST_DATA) && w_byte_valid) begin
                r_shadow[r_idx[2:0]] <= w_byte;
                r_chk                <= r_chk ^ w_byte;
                r_idx                <= r_idx + 4'd1;
            end

            // Entries beyond N are cleared so stale shadow data never becomes visible.
            if (r_state == ST_COMMIT) begin
                for (int i = 0; i < MAX_ENTRIES; i++)
                    r_active[i] <= (4'(i) < r_n) ? r_shadow[i] : 8'h00;
            end
        end
    end

    assign rd_opcode  = r_active[rd_addr][7:4];
    assign rd_arg     = r_active[rd_addr][3:0];
    assign cpu_hold   = (r_state != ST_IDLE);
    assign load_done  = r_done;
    assign load_error = r_err;

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - directed self-checking bench for program_loader
`timescale 1ns/1ps
module tb_program_loader;

    localparam int CLK_HZ = 1000000;
    localparam int BAUD   = 50000;
    localparam int BIT    = CLK_HZ / BAUD;
    localparam int TMO    = 20 * BIT;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;
    logic       rx      = 1'b1;
    logic [2:0] rd_addr = 3'd0;
    logic [3:0] rd_opcode;
    logic [3:0] rd_arg;
    logic       cpu_hold;
    logic       load_done;
    logic       load_error;

    int n_cmp    = 0;
    int n_bad    = 0;
    int done_cnt = 0;
    int base;
    logic [7:0] exp_store [8];

    program_loader #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .TIMEOUT_CLKS(TMO), .SYNC_BYTE(8'hA5)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rx         (rx),
        .rd_addr    (rd_addr),
        .rd_opcode  (rd_opcode),
        .rd_arg     (rd_arg),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
        .load_error (load_error)
    );

    always #500 clk = ~clk;

    always @(negedge clk) if (load_done) done_cnt++;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_store(input string tag);
        for (int i = 0; i < 8; i++) begin
            rd_addr = 3'(i);
            #1;
            check_eq($sformatf("%s op[%0d]", tag, i), 32'(rd_opcode), 32'(exp_store[i][7:4]));
            check_eq($sformatf("%s arg[%0d]", tag, i), 32'(rd_arg), 32'(exp_store[i][3:0]));
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT) @(negedge clk);
        end
        rx = stop_bit;
        repeat (BIT) @(negedge clk);
        rx = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic set_exp(input logic [7:0] e0, input logic [7:0] e1);
        for (int i = 0; i < 8; i++) exp_store[i] = 8'h00;
        exp_store[0] = e0;
        exp_store[1] = e1;
    endtask

    initial begin
        set_exp(8'h00, 8'h00);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        // reset state
        check_eq("rst hold", 32'(cpu_hold), 32'd0);
        check_eq("rst done", 32'(load_done), 32'd0);
        check_eq("rst err", 32'(load_error), 32'd0);
        check_store("rst");

        // valid frame: chk = 02^1A^93 = 8B
        base = done_cnt;
        send_byte(8'hA5, 1'b1);
        check_eq("t1 hold after sync", 32'(cpu_hold), 32'd1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h1A, 1'b1);
        check_eq("t1 hold mid", 32'(cpu_hold), 32'd1);
        check_store("t1 old program");
        send_byte(8'h93, 1'b1);
        send_byte(8'h8B, 1'b1);
        check_eq("t1 done pulses", 32'(done_cnt - base), 32'd1);
        check_eq("t1 hold end", 32'(cpu_hold), 32'd0);
        check_eq("t1 err", 32'(load_error), 32'd0);
        set_exp(8'h1A, 8'h93);
        check_store("t1");

        // bad checksum
        base = done_cnt;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h1A, 1'b1);
        send_byte(8'h93, 1'b1);
        send_byte(8'h8C, 1'b1);
        check_eq("t2 err", 32'(load_error), 32'd1);
        check_eq("t2 done pulses", 32'(done_cnt - base), 32'd0);
        check_eq("t2 hold", 32'(cpu_hold), 32'd0);
        check_store("t2");

        // bad count, then a valid frame clears the error: chk = 01^47 = 46
        send_byte(8'hA5, 1'b1);
        check_eq("t3 err cleared by sync", 32'(load_error), 32'd0);
        check_eq("t3 hold after sync", 32'(cpu_hold), 32'd1);
        send_byte(8'h09, 1'b1);
        check_eq("t3 err n=9", 32'(load_error), 32'd1);
        check_eq("t3 hold n=9", 32'(cpu_hold), 32'd0);
        check_store("t3 unchanged");
        base = done_cnt;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h47, 1'b1);
        send_byte(8'h46, 1'b1);
        check_eq("t3 err after reload", 32'(load_error), 32'd0);
        check_eq("t3 done pulses", 32'(done_cnt - base), 32'd1);
        set_exp(8'h47, 8'h00);
        check_store("t3 reload");

        // framing error
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h55, 1'b0);
        check_eq("t4 err", 32'(load_error), 32'd1);
        check_eq("t4 hold", 32'(cpu_hold), 32'd0);
        check_eq("t4 state idle", 32'(dut.r_state), 32'd0);
        check_store("t4");

        // timeout
        send_byte(8'hA5, 1'b1);
        send_byte(8'h03, 1'b1);
        send_byte(8'h11, 1'b1);
        check_eq("t5 err before idle", 32'(load_error), 32'd0);
        check_eq("t5 hold before idle", 32'(cpu_hold), 32'd1);
        repeat (TMO + BIT) @(negedge clk);
        check_eq("t5 err", 32'(load_error), 32'd1);
        check_eq("t5 hold", 32'(cpu_hold), 32'd0);
        check_store("t5");

        // noise is ignored, then reset mid-DATA, then a fresh frame
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'h3C, 1'b1);
        check_eq("t6 noise hold", 32'(cpu_hold), 32'd0);
        check_eq("t6 noise err sticky", 32'(load_error), 32'd1);
        send_byte(8'hA5, 1'b1);
        check_eq("t6 hold after sync", 32'(cpu_hold), 32'd1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h1A, 1'b1);
        reset_n = 1'b0;
        #1;
        check_eq("t6 hold in reset", 32'(cpu_hold), 32'd0);
        check_eq("t6 err in reset", 32'(load_error), 32'd0);
        set_exp(8'h00, 8'h00);
        check_store("t6 reset");
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        base = done_cnt;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h1A, 1'b1);
        send_byte(8'h93, 1'b1);
        send_byte(8'h8B, 1'b1);
        check_eq("t6 done pulses", 32'(done_cnt - base), 32'd1);
        check_eq("t6 err", 32'(load_error), 32'd0);
        set_exp(8'h1A, 8'h93);
        check_store("t6 fresh");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
